// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display blocks: glyph table, blank pattern
// and arbiter state encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Segment order {a,b,c,d,e,f,g}; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_GLYPH_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] arb_gnt(input arb_state_e s);
    unique case (s)
      StOwn0:  arb_gnt = 2'b01;
      StOwn1:  arb_gnt = 2'b10;
      default: arb_gnt = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to 7-segment glyph decoder.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seven_seg_disp_arb.sv
// 4-digit multiplexed 7-segment scanner shared between two 16-bit hex sources,
// with per-frame arbitration, data snapshot, anti-ghost blanking and brightness PWM.
module seven_seg_disp_arb
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned HOLD_FRAMES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [3:0]  brightness,
  output logic [1:0]  gnt,
  output logic        frame_tick,
  output logic [3:0]  a,
  output logic [6:0]  k
);

  localparam int unsigned CntW  = $clog2(CLK_DIV);
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

  logic [CntW-1:0]  r_slot_cnt;
  logic [1:0]       r_sel;
  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [HoldW-1:0] r_hold_cnt;
  logic             r_last;
  logic [15:0]      r_shadow;
  logic [15:0]      w_shadow_nxt;
  logic             w_slot_end;
  logic             w_fb;
  logic             w_hold_done;
  logic             w_lit;
  logic [3:0]       w_nibble;
  logic [6:0]       w_glyph;

  assign w_slot_end  = (r_slot_cnt == CntW'(CLK_DIV - 1));
  assign w_fb        = w_slot_end && (r_sel == 2'd3);
  assign w_hold_done = (r_hold_cnt == HoldW'(HOLD_FRAMES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_sel      <= 2'd0;
    end else if (w_slot_end) begin
      r_slot_cnt <= '0;
      r_sel      <= r_sel + 2'd1;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  // Next owner, evaluated every cycle but only committed on a frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        case (req)
          2'b01:   w_state_nxt = StOwn0;
          2'b10:   w_state_nxt = StOwn1;
          2'b11:   w_state_nxt = r_last ? StOwn0 : StOwn1;
          default: w_state_nxt = StIdle;
        endcase
      end
      StOwn0: begin
        if (!req[0])                     w_state_nxt = req[1] ? StOwn1 : StIdle;
        else if (req[1] && w_hold_done)  w_state_nxt = StOwn1;
      end
      StOwn1: begin
        if (!req[1])                     w_state_nxt = req[0] ? StOwn0 : StIdle;
        else if (req[0] && w_hold_done)  w_state_nxt = StOwn0;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_shadow_nxt = 16'h0000;
    case (w_state_nxt)
      StOwn0:  w_shadow_nxt = data0;
      StOwn1:  w_shadow_nxt = data1;
      default: w_shadow_nxt = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
      r_last     <= 1'b1;
      r_shadow   <= 16'h0000;
      gnt        <= 2'b00;
    end else if (w_fb) begin
      r_state  <= w_state_nxt;
      gnt      <= arb_gnt(w_state_nxt);
      r_shadow <= w_shadow_nxt;
      if (w_state_nxt != r_state) begin
        r_hold_cnt <= '0;
      end else if ((r_state != StIdle) && !w_hold_done) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      if (w_state_nxt == StOwn0)      r_last <= 1'b0;
      else if (w_state_nxt == StOwn1) r_last <= 1'b1;
    end
  end

  assign w_nibble = r_shadow[4*r_sel +: 4];

  seven_seg_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Anodes stay dark during the blanking window and the PWM off-phase of each slot.
  assign w_lit = (r_state != StIdle) &&
                 (r_slot_cnt >= CntW'(BLANK_CYCLES)) &&
                 ((brightness == 4'd15) || (r_slot_cnt[3:0] < brightness));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= 4'b0000;
      k          <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      a          <= w_lit ? (4'b0001 << r_sel) : 4'b0000;
      k          <= w_glyph;
      frame_tick <= w_fb;
    end
  end

endmodule

// File: tb/tb_seven_seg_disp_arb.sv
// Self-checking bench for seven_seg_disp_arb: reference model feeding a scoreboard,
// plus directed checks for reset, scan glyphs, PWM, arbitration and tearing.
module tb_seven_seg_disp_arb;

  localparam int unsigned CLK_DIV = 20;
  localparam int unsigned BLANK   = 4;
  localparam int unsigned HOLD    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic [3:0]  brightness = 4'd0;
  logic [1:0]  gnt;
  logic        frame_tick;
  logic [3:0]  a;
  logic [6:0]  k;

  always #5 clk = ~clk;

  seven_seg_disp_arb #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK),
    .HOLD_FRAMES  (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .brightness (brightness),
    .gnt        (gnt),
    .frame_tick (frame_tick),
    .a          (a),
    .k          (k)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
  endtask

  logic [6:0] glyph_tb [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: state 0=idle, 1=own0, 2=own1.
  int          m_slot = 0, m_sel = 0, m_state = 0, m_hold = 0, m_last = 1;
  logic [15:0] m_shadow = 16'h0000;
  logic [13:0] exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    logic       slot_end, fb;
    logic [6:0] ek;
    logic [3:0] ea;
    logic [1:0] eg;
    logic [3:0] nib;
    int         nxt;
    if (!rst_n) begin
      m_slot = 0; m_sel = 0; m_state = 0; m_hold = 0; m_last = 1;
      m_shadow = 16'h0000;
      exp_q.delete();
    end else begin
      slot_end = (m_slot == CLK_DIV - 1);
      fb       = slot_end && (m_sel == 3);
      nib      = m_shadow[4*m_sel +: 4];
      ek       = glyph_tb[nib];
      ea       = ((m_state != 0) && (m_slot >= BLANK) &&
                  ((brightness == 4'd15) || ((m_slot % 16) < brightness))) ?
                 4'(1 << m_sel) : 4'b0000;
      if (fb) begin
        nxt = m_state;
        case (m_state)
          0: nxt = (req == 2'b00) ? 0 : (req == 2'b01) ? 1 : (req == 2'b10) ? 2 :
                   ((m_last == 0) ? 2 : 1);
          1: nxt = !req[0] ? (req[1] ? 2 : 0) : ((req[1] && m_hold == HOLD) ? 2 : 1);
          default: nxt = !req[1] ? (req[0] ? 1 : 0) : ((req[0] && m_hold == HOLD) ? 1 : 2);
        endcase
        if (nxt != m_state) m_hold = 0;
        else if (m_state != 0 && m_hold < HOLD) m_hold++;
        if (nxt != 0) m_last = nxt - 1;
        m_state  = nxt;
        m_shadow = (nxt == 1) ? data0 : (nxt == 2) ? data1 : 16'h0000;
      end
      eg = (m_state == 1) ? 2'b01 : (m_state == 2) ? 2'b10 : 2'b00;
      if (slot_end) begin
        m_slot = 0;
        m_sel  = (m_sel + 1) % 4;
      end else begin
        m_slot++;
      end
      exp_q.push_back({eg, fb, ea, ek});
    end
  end

  always @(negedge clk) begin
    logic [13:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("scoreboard{gnt,tick,a,k}", {18'd0, gnt, frame_tick, a, k}, {18'd0, e});
    end
  end

  task automatic wait_tick();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_tick && c < 400);
    check_eq("tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    check_eq({tag, "_a"}, {28'd0, a}, 32'd0);
    check_eq({tag, "_k"}, {25'd0, k}, 32'd0);
    check_eq({tag, "_tick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  task automatic check_first_tick(input string tag);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_tick && c < 200);
    check_eq(tag, c, 32'd80);
  endtask

  logic [6:0] exp_digit [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
  logic [1:0] exp_gnt_seq [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    // Reset held with random inputs
    repeat (5) begin
      @(negedge clk);
      req = 2'($urandom); data0 = 16'($urandom); data1 = 16'($urandom);
      brightness = 4'($urandom);
      check_cleared("reset");
    end
    req = 2'b00; data0 = 16'h1234; data1 = 16'h0000; brightness = 4'd15;
    @(negedge clk);
    rst_n = 1'b1;
    check_first_tick("first_tick_latency");

    // Scan with source 0 granted
    req = 2'b01;
    wait_tick();
    check_eq("scan_gnt", {30'd0, gnt}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 10 : 20) @(negedge clk);
      check_eq("scan_a", {28'd0, a}, 32'(1 << d));
      check_eq("scan_k", {25'd0, k}, {25'd0, exp_digit[d]});
    end

    // Mid-frame data change must not tear the current frame
    data0 = 16'hABCD;
    repeat (5) @(negedge clk);
    check_eq("tear_old_k", {25'd0, k}, {25'd0, 7'b0110000});
    wait_tick();
    repeat (10) @(negedge clk);
    check_eq("tear_new_k0", {25'd0, k}, {25'd0, 7'b0111101});
    repeat (60) @(negedge clk);
    check_eq("tear_new_k3", {25'd0, k}, {25'd0, 7'b1110111});

    // PWM: dark, then half brightness
    brightness = 4'd0;
    repeat (160) begin
      @(negedge clk);
      check_eq("pwm_dark_a", {28'd0, a}, 32'd0);
    end
    brightness = 4'd8;
    repeat (160) @(negedge clk);
    brightness = 4'd15;

    // Release to idle, then other source takes over
    wait_tick();
    req = 2'b00;
    wait_tick();
    check_eq("release_gnt", {30'd0, gnt}, 32'd0);
    repeat (30) @(negedge clk);
    check_eq("release_a", {28'd0, a}, 32'd0);
    req = 2'b10;
    wait_tick();
    check_eq("other_gnt", {30'd0, gnt}, 32'd2);

    // Contention from idle with last owner = source 1
    req = 2'b00;
    wait_tick();
    req = 2'b11;
    for (int i = 0; i < 7; i++) begin
      wait_tick();
      check_eq("contend_gnt", {30'd0, gnt}, {30'd0, exp_gnt_seq[i]});
    end

    // Asynchronous reset mid-slot
    repeat (33) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_cleared("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_first_tick("restart_tick_latency");

    // Random traffic against the scoreboard
    repeat (1200) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) req = 2'($urandom);
      if ($urandom_range(0, 15) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) data1 = 16'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
